pooling_2d_cdc_tx: RTL and testbench
====================================

POOLING_2D_CDC_TX -- requirements
Module: pooling_2d_cdc_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of the transferred word.
REQ-002 SHALL have parameter CYCLES, default 2, the number of synchronizer flops on cdc_ack; legal range 2..4.
REQ-003 SHALL have parameter TIMEOUT, default 1024, the WAIT-cycle limit before flagging an error; 0 disables the watchdog.
REQ-004 SHALL have port clk, input, 1 bit: the single source-domain clock.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: the upstream word is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a word.
REQ-008 SHALL have port in_data, input, DATA_WIDTH bits: the upstream word.
REQ-009 SHALL have port cdc_req, output, 1 bit: a registered two-phase request toggle to the receiving domain.
REQ-010 SHALL have port cdc_data, output, DATA_WIDTH bits: a registered data bus, held stable while a request is outstanding.
REQ-011 SHALL have port cdc_ack, input, 1 bit: an asynchronous two-phase acknowledge toggle from the receiver.
REQ-012 SHALL have port done, output, 1 bit: a one-cycle pulse when the acknowledge completes.
REQ-013 SHALL have port err, output, 1 bit: a sticky error flag covering timeout or a spurious acknowledge.

Function
REQ-014 SHALL pass cdc_ack through a CYCLES-deep flop chain clocked by clk; ack_s is the last stage, and no other logic SHALL sample raw cdc_ack.
REQ-015 SHALL implement a two-state FSM: IDLE and WAIT.
REQ-016 SHALL drive in_ready = 1 exactly when the state is IDLE, decoded only from registered state (no combinational path from in_valid or cdc_ack).
REQ-017 SHALL, in IDLE with in_valid=1 at a clk edge: capture in_data into cdc_data, invert cdc_req, clear the wait counter, and enter WAIT, all on that same edge.
REQ-018 SHALL, in IDLE with in_valid=0, hold all outputs.
REQ-019 SHALL keep cdc_data and cdc_req unchanged throughout WAIT, regardless of in_valid or in_data.
REQ-020 SHALL, in WAIT when ack_s == cdc_req: return to IDLE on the next edge and assert done for exactly that one cycle.
REQ-021 SHALL not accept a new word in the cycle done is high; the earliest next acceptance is the cycle after done, giving a one-cycle bubble.
REQ-022 SHALL, in WAIT, increment a wait counter each cycle that ack_s != cdc_req, saturating at TIMEOUT.
REQ-023 SHALL set err when the wait counter reaches TIMEOUT (TIMEOUT>0); the FSM SHALL remain in WAIT with no retransmit.
REQ-024 SHALL set err when ack_s != cdc_req in IDLE (a spurious acknowledge toggle), and SHALL NOT change the FSM state in that case.
REQ-025 SHALL clear err only by reset.
REQ-026 SHALL give a minimum round trip, from acceptance to done, of CYCLES + receiver latency + 1 cycles.

Reset
REQ-027 SHALL, while reset=1, force: state=IDLE, in_ready=1, cdc_req=0, cdc_data=0, done=0, err=0, wait counter=0, and every ack synchronizer flop=0.
REQ-028 SHALL, on reset asserted mid-WAIT, abandon the transfer with no done pulse; the receiver SHALL be reset in the same system reset so its ack returns to 0.
REQ-029 SHALL accept a word on the first clk edge after reset deasserts, if in_valid=1.

Verification
REQ-030 SHALL cover single transfer: in_data=0xA5A5_0001 with in_valid for 1 cycle, ack looped back after a 3-cycle delay -> cdc_req 0->1, cdc_data=0xA5A5_0001 stable until done, one done pulse, in_ready high again the cycle after done.
REQ-031 SHALL cover back-to-back transfers: in_valid held high with 4 words 0x1..0x4 -> cdc_req toggles 4 times, cdc_data sequence 1,2,3,4, 4 done pulses, one bubble cycle between each.
REQ-032 SHALL cover data hold: in_data changing every cycle during WAIT -> cdc_data unchanged until done.
REQ-033 SHALL cover timeout: TIMEOUT=16, ack never returned -> err=1 after 16 WAIT cycles, in_ready=0, no done.
REQ-034 SHALL cover spurious acknowledge: cdc_ack toggled while IDLE -> err=1 CYCLES+1 edges later, state stays IDLE.
REQ-035 SHALL cover reset mid-WAIT: reset pulsed 2 cycles during WAIT -> all outputs at reset values, a new transfer after release completes normally with cdc_req 0->1.

Source files
------------

// File: rtl/pooling_2d_cdc_tx.sv
// pooling_2d_cdc_tx
// Source side of a two-phase (toggle) request/acknowledge crossing.
// A word accepted on the in_valid/in_ready handshake is registered onto
// cdc_data and announced by toggling cdc_req. The receiver answers by
// toggling cdc_ack to match. cdc_ack is asynchronous, so it passes through
// a short flop chain before anything looks at it. A watchdog flags a
// receiver that never answers. A separate check flags an acknowledge
// toggle that arrives with no request outstanding. The error flag is
// sticky until reset.

module pooling_2d_cdc_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int CYCLES     = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  cdc_req,
  output logic [DATA_WIDTH-1:0] cdc_data,
  input  logic                  cdc_ack,
  output logic                  done,
  output logic                  err
);

  // Synchronizer depth is clamped into the supported 2..4 range.
  localparam int SYNC_N = (CYCLES < 2) ? 2 : ((CYCLES > 4) ? 4 : CYCLES);

  // The wait counter only needs to reach TIMEOUT.
  // A TIMEOUT of zero disables the watchdog. In that case a 1-bit counter
  // is kept so that the logic stays well formed.
  localparam int               CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam bit               WDOG_EN = (TIMEOUT > 0);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_nextState;

  logic [SYNC_N-1:0]     r_ackSync;
  logic                  w_ackS;
  logic                  w_ackMismatch;

  logic                  r_req;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_done;
  logic                  r_err;
  logic [CNT_W-1:0]      r_waitCnt;
  logic [CNT_W-1:0]      w_waitCntNext;

  logic                  w_accept;
  logic                  w_complete;
  logic                  w_spurious;
  logic                  w_timeoutHit;

  // Bring the asynchronous acknowledge toggle into the clk domain; only the last stage is used.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ackSync <= '0;
    end else begin
      r_ackSync <= {r_ackSync[SYNC_N-2:0], cdc_ack};
    end
  end

  assign w_ackS        = r_ackSync[SYNC_N-1];
  assign w_ackMismatch = (w_ackS != r_req);

  // The done cycle is kept out of acceptance, which leaves a one-cycle bubble after every transfer.
  assign in_ready = (r_state == ST_IDLE) && !r_done;

  // State register for the IDLE/WAIT handshake controller.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and event decode: acceptance, completion and spurious acknowledge.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    w_spurious  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ackMismatch) begin
          w_spurious = 1'b1;
        end
        if (in_valid && !r_done) begin
          w_accept    = 1'b1;
          w_nextState = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!w_ackMismatch) begin
          w_complete  = 1'b1;
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // The wait counter restarts on acceptance. While the receiver is silent it counts up and holds at TIMEOUT.
  always_comb begin
    w_waitCntNext = r_waitCnt;
    w_timeoutHit  = 1'b0;
    if (w_accept) begin
      w_waitCntNext = '0;
    end else if ((r_state == ST_WAIT) && w_ackMismatch && (r_waitCnt != CNT_MAX)) begin
      w_waitCntNext = r_waitCnt + CNT_W'(1);
    end
    if (WDOG_EN && (r_state == ST_WAIT) && (w_waitCntNext == CNT_MAX)) begin
      w_timeoutHit = 1'b1;
    end
  end

  // Crossing-side registers hold still for the whole transfer; done pulses once and err stays set until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req     <= 1'b0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_waitCnt <= '0;
    end else begin
      r_done    <= w_complete;
      r_waitCnt <= w_waitCntNext;
      if (w_accept) begin
        r_req  <= ~r_req;
        r_data <= in_data;
      end
      if (w_spurious || w_timeoutHit) begin
        r_err <= 1'b1;
      end
    end
  end

  assign cdc_req  = r_req;
  assign cdc_data = r_data;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_pooling_2d_cdc_tx.sv
// tb_pooling_2d_cdc_tx
// Directed bench for pooling_2d_cdc_tx with a looped-back receiver.
// The driver queues each accepted word together with its expected request phase.
// A monitor consumes the queue whenever cdc_req toggles, and it checks
// every done pulse.

module tb_pooling_2d_cdc_tx;

  localparam int DW  = 32;
  localparam int CYC = 2;
  localparam int TMO = 16;
  // Acceptance edge to done: receiver answers about 2.5 cycles after the toggle,
  // then CYC synchronizer edges, then one edge to complete.
  localparam int LAT = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          cdc_req;
  logic [DW-1:0] cdc_data;
  logic          cdc_ack = 1'b0;
  logic          done;
  logic          err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          req;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;

  logic          modelReq = 1'b0;
  logic          rxEnable;
  int            spurCount = 0;
  int            spurSeen  = 0;
  logic [2:0]    rxPipe    = 3'b000;

  int            cycle         = 0;
  int            doneCount     = 0;
  logic          outstanding   = 1'b0;
  int            reqCycle      = 0;
  int            lastDoneCycle = -100;
  logic          prevReq       = 1'b0;
  logic          prevDone      = 1'b0;
  logic [DW-1:0] heldData      = '0;
  logic          burstMode     = 1'b0;
  int            burstStart    = 0;

  pooling_2d_cdc_tx #(
    .DATA_WIDTH(DW),
    .CYCLES    (CYC),
    .TIMEOUT   (TMO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .cdc_req (cdc_req),
    .cdc_data(cdc_data),
    .cdc_ack (cdc_ack),
    .done    (done),
    .err     (err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter so that latencies can be measured in edges.
  always @(posedge clk) cycle <= cycle + 1;

  // Receiver stand-in: echoes cdc_req back on cdc_ack three negedges later, or flips it on demand.
  always @(negedge clk) begin
    if (reset) begin
      rxPipe   = 3'b000;
      cdc_ack  = 1'b0;
      spurSeen = spurCount;
    end else begin
      if (rxEnable) begin
        rxPipe  = {rxPipe[1:0], cdc_req};
        cdc_ack = rxPipe[2];
      end
      if (spurCount != spurSeen) begin
        cdc_ack  = ~cdc_ack;
        spurSeen = spurCount;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Monitor: pops the queue on every request toggle, holds data stable while outstanding, and validates done pulses.
  always @(negedge clk) begin
    if (reset) begin
      prevReq     = cdc_req;
      prevDone    = 1'b0;
      outstanding = 1'b0;
    end else begin
      if (cdc_req !== prevReq) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_req", 64'(1), 64'(0));
        end else begin
          monExp = expQ.pop_front();
          checkOutput("cdc_data", 64'(cdc_data), 64'(monExp.data));
          checkOutput("cdc_req", 64'(cdc_req), 64'(monExp.req));
        end
        checkOutput("req_while_busy", 64'(outstanding), 64'(0));
        // Done seen in cycle D, in_ready high in D+1, accepted at the end of D+1, toggle visible in D+2.
        if (burstMode && (lastDoneCycle >= burstStart)) begin
          checkOutput("bubble", 64'(cycle - lastDoneCycle), 64'(2));
        end
        outstanding = 1'b1;
        reqCycle    = cycle;
        heldData    = cdc_data;
        prevReq     = cdc_req;
      end else if (outstanding) begin
        checkOutput("data_hold", 64'(cdc_data), 64'(heldData));
      end
      if (done === 1'b1) begin
        checkOutput("done_outstanding", 64'(outstanding), 64'(1));
        checkOutput("done_latency", 64'(cycle - reqCycle), 64'(LAT));
        checkOutput("done_width", 64'(prevDone), 64'(0));
        checkOutput("ready_in_done", 64'(in_ready), 64'(0));
        outstanding   = 1'b0;
        lastDoneCycle = cycle;
        doneCount++;
      end
      prevDone = done;
    end
  end

  task automatic applyReset(input int n);
    @(negedge clk);
    reset    = 1'b1;
    modelReq = 1'b0;
    rxEnable = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checkOutput("rst_ready", 64'(in_ready), 64'(1));
      checkOutput("rst_req", 64'(cdc_req), 64'(0));
      checkOutput("rst_data", 64'(cdc_data), 64'(0));
      checkOutput("rst_done", 64'(done), 64'(0));
      checkOutput("rst_err", 64'(err), 64'(0));
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic sendWord(input logic [DW-1:0] word, input bit hold, input bit noWait);
    bit ok;
    ok = 1'b0;
    if (!noWait) @(negedge clk);
    in_valid = 1'b1;
    in_data  = word;
    for (int i = 0; i < 100; i++) begin
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checkOutput("accept_wait", 64'(0), 64'(1));
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    modelReq = ~modelReq;
    expQ.push_back('{data: word, req: modelReq});
    @(negedge clk);
    checkOutput("accept_edge", 64'(cdc_req), 64'(modelReq));
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic waitDone(input int target);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (doneCount >= target) break;
    end
    checkOutput("done_count", 64'(doneCount), 64'(target));
  endtask

  task automatic applyStimulus();
    int base;

    // Single transfer, offered on the very edge after reset release.
    applyReset(3);
    base = doneCount;
    sendWord(32'hA5A5_0001, 1'b0, 1'b1);
    checkOutput("single_busy", 64'(in_ready), 64'(0));
    waitDone(base + 1);
    @(negedge clk);
    checkOutput("single_ready_after", 64'(in_ready), 64'(1));
    checkOutput("single_err", 64'(err), 64'(0));

    // Back-to-back words with in_valid held high.
    base       = doneCount;
    burstStart = cycle;
    burstMode  = 1'b1;
    sendWord(32'h0000_0001, 1'b1, 1'b0);
    sendWord(32'h0000_0002, 1'b1, 1'b0);
    sendWord(32'h0000_0003, 1'b1, 1'b0);
    sendWord(32'h0000_0004, 1'b0, 1'b0);
    waitDone(base + 4);
    burstMode = 1'b0;
    checkOutput("b2b_err", 64'(err), 64'(0));

    // Upstream keeps changing in_data, and briefly raises in_valid, while the transfer is outstanding.
    base = doneCount;
    sendWord(32'h5A5A_F00D, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = (i < 3);
      in_data  = $urandom;
      #1;
      if (doneCount >= base + 1) break;
    end
    in_valid = 1'b0;
    checkOutput("hold_done", 64'(doneCount), 64'(base + 1));
    checkOutput("hold_final_data", 64'(cdc_data), 64'(32'h5A5A_F00D));

    // Reset pulsed mid-WAIT, followed by a fresh transfer.
    base = doneCount;
    sendWord(32'hCAFE_0002, 1'b0, 1'b0);
    applyReset(2);
    repeat (4) @(negedge clk);
    checkOutput("no_done_after_reset", 64'(doneCount), 64'(base));
    sendWord(32'h1234_5678, 1'b0, 1'b0);
    waitDone(base + 1);
    checkOutput("post_reset_err", 64'(err), 64'(0));

    // Spurious acknowledge toggle while idle.
    @(negedge clk);
    rxEnable = 1'b0;
    @(posedge clk);
    #1;
    spurCount++;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("spur_err_early", 64'(err), 64'(0));
    @(negedge clk);
    checkOutput("spur_err", 64'(err), 64'(1));
    checkOutput("spur_idle", 64'(in_ready), 64'(1));
    repeat (4) @(negedge clk);
    checkOutput("spur_still_idle", 64'(in_ready), 64'(1));
    checkOutput("spur_sticky", 64'(err), 64'(1));

    // Receiver that never answers: the watchdog must fire after TMO wait cycles.
    applyReset(2);
    rxEnable = 1'b0;
    base     = doneCount;
    sendWord(32'hDEAD_BEEF, 1'b0, 1'b0);
    repeat (TMO - 1) @(negedge clk);
    checkOutput("tmo_err_early", 64'(err), 64'(0));
    @(negedge clk);
    checkOutput("tmo_err", 64'(err), 64'(1));
    checkOutput("tmo_ready", 64'(in_ready), 64'(0));
    repeat (8) @(negedge clk);
    checkOutput("tmo_no_done", 64'(doneCount), 64'(base));
    checkOutput("tmo_still_wait", 64'(in_ready), 64'(0));
    checkOutput("tmo_req_held", 64'(cdc_req), 64'(1));
    checkOutput("tmo_sticky", 64'(err), 64'(1));

    applyReset(2);
    checkOutput("queue_empty", 64'(expQ.size()), 64'(0));
  endtask

  // Main sequence.
  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    rxEnable = 1'b1;
    applyStimulus();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation stalled at cycle %0d", cycle);
    $fatal(1, "[TB] stalled");
  end

endmodule
